gf2_31_prng_ctrl: RTL and testbench
===================================

GF2_31_PRNG_CTRL -- requirements
Module: gf2_31_prng_ctrl

Interface
REQ-001 SHALL have parameter W, default 31: word width in bits.
REQ-002 SHALL have parameter N, default 5: history depth, equal to the XOR-tree fan-in.
REQ-003 SHALL have parameter WARMUP_STEPS, default 8: number of discarded steps, range 0..255.
REQ-004 SHALL have port clk, input, 1: the single clock; all state is rising-edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port clear, input, 1: synchronous abort to IDLE.
REQ-007 SHALL have port tap_mask, input, N: history-word select, sampled on the first seed accept.
REQ-008 SHALL have port seed_valid, input, 1: seed word offered.
REQ-009 SHALL have port seed_data, input, W: seed word.
REQ-010 SHALL have port seed_ready, output, 1: seed word accepted when seed_valid is also high.
REQ-011 SHALL have port out_valid, output, 1: random word available.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the word.
REQ-013 SHALL have port out_data, output, W: random word.
REQ-014 SHALL have port busy, output, 1: high in SEED or WARMUP.
REQ-015 SHALL have port zero_seed, output, 1: sticky error flag, all-zero seed rejected.

Function
REQ-016 SHALL hold history registers hist[0..N-1]; hist[0] is the newest word and hist[N-1] the oldest.
REQ-017 SHALL form the step word as the XOR over i of hist[i], for each i where m[i]=1; m = latched tap_mask with bit N-1 forced to 1.
REQ-018 SHALL perform a step as: shift hist[i] into hist[i+1], then load the step word into hist[0], all in one cycle.
REQ-019 SHALL implement FSM states IDLE, SEED, WARMUP and RUN.
REQ-020 SHALL assert seed_ready only in IDLE and SEED.
  - Each accepted seed word shifts into hist[0] with no XOR applied.
  - The first accept in IDLE latches tap_mask, clears zero_seed and enters SEED.
REQ-021 SHALL, on the N-th accepted seed word:
  - if the OR of all N seed words is zero: set zero_seed and go to IDLE;
  - otherwise, if WARMUP_STEPS>0: go to WARMUP;
  - otherwise: go to RUN.
REQ-022 SHALL, in WARMUP, step every cycle for exactly WARMUP_STEPS cycles, then enter RUN.
REQ-023 SHALL, in RUN, keep out_valid=1 and out_data=hist[0] as registered values.
  - out_valid&out_ready steps the history in that cycle.
  - Without the handshake, out_data SHALL be held stable.
REQ-024 SHALL give one-word-per-cycle throughput when out_ready is held high; the first out_valid appears in the cycle after entering RUN.
REQ-025 SHALL give clear priority over every other event: next state IDLE, seed count 0, out_valid 0, hist unchanged, zero_seed unchanged.
  - A seed handshake in the same cycle as clear SHALL be ignored.
REQ-026 SHALL NOT accept a new seed while in RUN; re-seeding requires clear first.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously set: state IDLE, all hist 0, m all 0, counters 0, out_valid 0, out_data 0, seed_ready 0, busy 0, zero_seed 0.
REQ-028 SHALL drive seed_ready=1 from the first clock edge after reset release; a reset mid-SEED or mid-RUN discards all progress.

Configuration
REQ-029 SHALL compile the WARMUP state, its counter and the WARMUP_STEPS parameter only when GF2_PRNG_WARMUP_EN is defined.
REQ-030 SHALL, without GF2_PRNG_WARMUP_EN, go from SEED directly to RUN; there is no WARMUP state and WARMUP_STEPS is ignored.

Structure
REQ-031 SHALL take W, N and the FSM state encoding from shared package gf2_31_prng_pkg.
REQ-032 SHALL compute the step word in one instance of sub-module xor_tree_5_31.
  - Input: the N masked hist words concatenated, hist[0] in the low bits.
  - Output: the step word.

Verification (W=31, N=5, macro undefined unless stated)
REQ-033 SHALL cover: seeds 1,2,4,8,16, tap_mask=5'b11111, out_ready=1 -> out_data 16, 31, 1 on consecutive cycles.
REQ-034 SHALL cover: same seeds, tap_mask=5'b00000 (oldest-word tap only) -> out_data 16, 1, 2, 4, 8, 16, period 5.
REQ-035 SHALL cover: five zero seed words -> zero_seed=1, state IDLE, out_valid stays 0, seed_ready=1.
REQ-036 SHALL cover: out_ready low for 3 cycles in RUN -> out_data stable at 16 and no step; release -> 31 on the next word.
REQ-037 SHALL cover: clear asserted after the 3rd seed word, then 5 new seeds -> sequence matches REQ-033 exactly.
REQ-038 SHALL cover: GF2_PRNG_WARMUP_EN defined, WARMUP_STEPS=8 -> busy high exactly 8 cycles after the 5th seed accept; first out_data equals the 9th word of the undefined-macro sequence.

Source files
------------

// File: rtl/gf2_31_prng_pkg.sv
// rtl/gf2_31_prng_pkg.sv - shared widths and FSM encoding for the GF(2) PRNG controller
// WARMUP state exists only when GF2_PRNG_WARMUP_EN is defined.
package gf2_31_prng_pkg;

    localparam int GF_W = 31;
    localparam int GF_N = 5;

`ifdef GF2_PRNG_WARMUP_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_RUN    = 2'd2,
        ST_WARMUP = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2
    } state_e;
`endif

endpackage

// File: rtl/gf2_31_prng_ctrl_if.sv
// rtl/gf2_31_prng_ctrl_if.sv - seed and output stream handshakes of the PRNG controller
interface gf2_31_prng_ctrl_if
    import gf2_31_prng_pkg::*;
#(
    parameter int W = GF_W
);
    logic         seed_valid;
    logic [W-1:0] seed_data;
    logic         seed_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output seed_valid, seed_data, out_ready,
        input  seed_ready, out_valid, out_data
    );

    modport slave (
        input  seed_valid, seed_data, out_ready,
        output seed_ready, out_valid, out_data
    );
endinterface

// File: rtl/xor_tree_5_31.sv
// rtl/xor_tree_5_31.sv - XOR reduction of N pre-masked history words into one step word
module xor_tree_5_31
    import gf2_31_prng_pkg::*;
#(
    parameter int W = GF_W,
    parameter int N = GF_N
) (
    input  logic [N*W-1:0] words_i,
    output logic [W-1:0]   word_o
);

    always_comb begin
        word_o = '0;
        for (int i = 0; i < N; i++) begin
            word_o = word_o ^ words_i[i*W +: W];
        end
    end

endmodule

// File: rtl/gf2_31_prng_ctrl.sv
// rtl/gf2_31_prng_ctrl.sv - seeded GF(2) history-XOR PRNG with seed/output handshakes
// Optional warm-up phase compiled in with GF2_PRNG_WARMUP_EN.
module gf2_31_prng_ctrl
    import gf2_31_prng_pkg::*;
#(
    parameter int W = GF_W,
    parameter int N = GF_N
`ifdef GF2_PRNG_WARMUP_EN
    ,
    parameter int WARMUP_STEPS = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [N-1:0]         tap_mask,
    gf2_31_prng_ctrl_if.slave    bus,
    output logic                 busy,
    output logic                 zero_seed
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] OLDEST = {1'b1, {(N-1){1'b0}}};

    state_e         state_q, state_d;
    logic [W-1:0]   hist_q [N];
    logic [W-1:0]   hist_d [N];
    logic [N-1:0]   m_q, m_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           out_valid_q, out_valid_d;
    logic           seed_ready_q, seed_ready_d;
    logic           busy_q, busy_d;
    logic           zero_q, zero_d;
`ifdef GF2_PRNG_WARMUP_EN
    logic [7:0]     warm_q, warm_d;
`endif

    logic [N*W-1:0] masked;
    logic [W-1:0]   step_word;
    logic [W-1:0]   shift_word;
    logic           shift_en;
    logic           seed_fire;
    logic           seed_or;

    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) begin
            if (m_q[i]) masked[i*W +: W] = hist_q[i];
        end
    end

    xor_tree_5_31 #(.W(W), .N(N)) u_xor_tree (
        .words_i (masked),
        .word_o  (step_word)
    );

    // On the last seed accept the N seeds are the incoming word plus hist[0..N-2].
    always_comb begin
        seed_or = |bus.seed_data;
        for (int i = 0; i < N - 1; i++) begin
            seed_or = seed_or | (|hist_q[i]);
        end
    end

    assign seed_fire = bus.seed_valid && seed_ready_q;

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        zero_d     = zero_q;
        shift_en   = 1'b0;
        shift_word = step_word;
`ifdef GF2_PRNG_WARMUP_EN
        warm_d     = warm_q;
`endif
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
`ifdef GF2_PRNG_WARMUP_EN
            warm_d  = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_SEED: begin
                    if (seed_fire) begin
                        shift_en   = 1'b1;
                        shift_word = bus.seed_data;
                        if (state_q == ST_IDLE) begin
                            m_d    = tap_mask | OLDEST;
                            zero_d = 1'b0;
                        end
                        if (int'(cnt_q) == N - 1) begin
                            cnt_d = '0;
                            if (!seed_or) begin
                                zero_d  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
`ifdef GF2_PRNG_WARMUP_EN
                                state_d = (WARMUP_STEPS > 0) ? ST_WARMUP : ST_RUN;
`else
                                state_d = ST_RUN;
`endif
                            end
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = ST_SEED;
                        end
                    end
                end
`ifdef GF2_PRNG_WARMUP_EN
                ST_WARMUP: begin
                    shift_en = 1'b1;
                    if (int'(warm_q) == WARMUP_STEPS - 1) begin
                        warm_d  = '0;
                        state_d = ST_RUN;
                    end else begin
                        warm_d = warm_q + 8'd1;
                    end
                end
`endif
                ST_RUN: begin
                    if (out_valid_q && bus.out_ready) shift_en = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        hist_d = hist_q;
        if (shift_en) begin
            hist_d[0] = shift_word;
            for (int i = 1; i < N; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    // Handshake/status outputs are registered copies of the next state.
    always_comb begin
        out_valid_d  = (state_d == ST_RUN);
        seed_ready_d = (state_d == ST_IDLE) || (state_d == ST_SEED);
`ifdef GF2_PRNG_WARMUP_EN
        busy_d       = (state_d == ST_SEED) || (state_d == ST_WARMUP);
`else
        busy_d       = (state_d == ST_SEED);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            m_q          <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            seed_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            zero_q       <= 1'b0;
            for (int i = 0; i < N; i++) begin
                hist_q[i] <= '0;
            end
`ifdef GF2_PRNG_WARMUP_EN
            warm_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            m_q          <= m_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            seed_ready_q <= seed_ready_d;
            busy_q       <= busy_d;
            zero_q       <= zero_d;
            for (int i = 0; i < N; i++) begin
                hist_q[i] <= hist_d[i];
            end
`ifdef GF2_PRNG_WARMUP_EN
            warm_q       <= warm_d;
`endif
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = hist_q[0];
    assign bus.seed_ready = seed_ready_q;
    assign busy           = busy_q;
    assign zero_seed      = zero_q;

endmodule

// File: tb/tb_gf2_31_prng_ctrl.sv
// tb/tb_gf2_31_prng_ctrl.sv - scoreboard bench for gf2_31_prng_ctrl with a queue-based reference model
// Model applies the warm-up steps when GF2_PRNG_WARMUP_EN is defined.
module tb_gf2_31_prng_ctrl;
    import gf2_31_prng_pkg::*;

    localparam int W = GF_W;
    localparam int N = GF_N;
`ifdef GF2_PRNG_WARMUP_EN
    localparam int WARM = 8;
`else
    localparam int WARM = 0;
`endif

    typedef logic [W-1:0] word_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic [N-1:0] tap_mask = '0;
    logic         busy;
    logic         zero_seed;

    gf2_31_prng_ctrl_if bus_if ();

    gf2_31_prng_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .tap_mask  (tap_mask),
        .bus       (bus_if),
        .busy      (busy),
        .zero_seed (zero_seed)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    word_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: newest word at the front, step word = XOR of tapped words (oldest always tapped).
    task automatic model_push(input word_t s[N], input logic [N-1:0] mask, input int nwords);
        word_t h[$];
        word_t x;
        for (int k = 0; k < N; k++) h.push_front(s[k]);
        for (int k = 0; k < WARM + nwords; k++) begin
            if (k >= WARM) exp_q.push_back(h[0]);
            x = '0;
            for (int i = 0; i < N; i++) begin
                if (i == N - 1 || mask[i]) x = x ^ h[i];
            end
            h.push_front(x);
            void'(h.pop_back());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus_if.out_valid) begin
            if (exp_q.size() > 0) begin
                check("out_data", bus_if.out_data, exp_q[0]);
                if (bus_if.out_ready) void'(exp_q.pop_front());
            end else if (bus_if.out_ready) begin
                check("spare_handshake", bus_if.out_ready, 1'b0);
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic send_seeds(input word_t s[N], input int n, input logic [N-1:0] mask, input bit gaps);
        bit acc;
        int guard;
        tap_mask = mask;
        for (int k = 0; k < n; k++) begin
            bus_if.seed_valid = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            bus_if.seed_valid = 1'b1;
            bus_if.seed_data  = s[k];
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 50) begin
                @(negedge clk);
                acc = bus_if.seed_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!acc) check("seed_accept_timeout", bus_if.seed_ready, 1'b1);
            if (k == 0) begin
                tap_mask = N'($urandom);
                if (n > 1) check("busy_in_seed", busy, 1'b1);
            end
        end
        bus_if.seed_valid = 1'b0;
    endtask

    // mode 0: ready held high; 1: random ready; 2: ready low for 3 valid cycles then high
    task automatic drain(input int mode);
        int guard = 0;
        if (mode == 2) begin
            bus_if.out_ready = 1'b0;
            do begin @(negedge clk); guard++; end while (!bus_if.out_valid && guard < 50);
            repeat (2) @(negedge clk);
            @(posedge clk); #1;
        end
        while (exp_q.size() > 0 && guard < 400) begin
            bus_if.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        bus_if.out_ready = 1'b0;
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_out_valid", bus_if.out_valid, 1'b0);
        check("clear_seed_ready", bus_if.seed_ready, 1'b1);
        check("clear_busy", busy, 1'b0);
    endtask

    task automatic directed(input word_t s[N], input logic [N-1:0] mask, input word_t e[$], input int mode);
`ifdef GF2_PRNG_WARMUP_EN
        int bcnt = 0;
        model_push(s, mask, e.size());
`else
        foreach (e[i]) exp_q.push_back(e[i]);
`endif
        bus_if.out_ready = (mode == 0);
        send_seeds(s, N, mask, 1'b0);
`ifdef GF2_PRNG_WARMUP_EN
        while (busy && bcnt < 40) begin @(posedge clk); #1; bcnt++; end
        check("warmup_busy_cycles", 64'(bcnt), 64'(WARM - 1));
`endif
        drain(mode);
    endtask

    initial begin : main
        word_t s_pow[N];
        word_t s_tmp[N];
        word_t e[$];
        logic [N-1:0] mk;

        bus_if.seed_valid = 1'b0;
        bus_if.seed_data  = '0;
        bus_if.out_ready  = 1'b0;
        s_pow = '{31'd1, 31'd2, 31'd4, 31'd8, 31'd16};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus_if.out_valid, 1'b0);
        check("rst_out_data", bus_if.out_data, 0);
        check("rst_seed_ready", bus_if.seed_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_zero_seed", zero_seed, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("seed_ready_after_rst", bus_if.seed_ready, 1'b1);

        e = '{31'd16, 31'd31, 31'd1};
        directed(s_pow, 5'b11111, e, 0);
        check("run_no_seed_ready", bus_if.seed_ready, 1'b0);
        check("run_not_busy", busy, 1'b0);
        do_clear();

        e = '{31'd16, 31'd1, 31'd2, 31'd4, 31'd8, 31'd16};
        directed(s_pow, 5'b00000, e, 0);
        do_clear();

        e = '{31'd16, 31'd31, 31'd1};
        directed(s_pow, 5'b11111, e, 2);
        do_clear();

        s_tmp = '{31'd7, 31'd9, 31'd11, 31'd0, 31'd0};
        send_seeds(s_tmp, 3, 5'b00101, 1'b1);
        bus_if.seed_valid = 1'b1;
        bus_if.seed_data  = 31'd5;
        do_clear();
        bus_if.seed_valid = 1'b0;
        e = '{31'd16, 31'd31, 31'd1};
        directed(s_pow, 5'b11111, e, 0);
        do_clear();

        s_tmp = '{default: '0};
        send_seeds(s_tmp, N, 5'b10101, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        check("zero_seed_flag", zero_seed, 1'b1);
        check("zero_out_valid", bus_if.out_valid, 1'b0);
        check("zero_seed_ready", bus_if.seed_ready, 1'b1);
        check("zero_busy", busy, 1'b0);

        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < N; k++) s_tmp[k] = W'($urandom);
            mk = N'($urandom);
            model_push(s_tmp, mk, 16);
            bus_if.out_ready = 1'b0;
            send_seeds(s_tmp, N, mk, 1'b1);
            if (it == 0) check("zero_seed_cleared", zero_seed, 1'b0);
            drain(1);
            do_clear();
        end

        for (int k = 0; k < N; k++) s_tmp[k] = W'($urandom) | 31'd1;
        send_seeds(s_tmp, N, 5'b01010, 1'b0);
        repeat (WARM + 1) begin @(posedge clk); #1; end
        check("pre_reset_out_valid", bus_if.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus_if.out_valid, 1'b0);
        check("async_rst_out_data", bus_if.out_data, 0);
        check("async_rst_seed_ready", bus_if.seed_ready, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        exp_q.delete();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("seed_ready_after_rst2", bus_if.seed_ready, 1'b1);

        e = '{31'd16, 31'd31, 31'd1};
        directed(s_pow, 5'b11111, e, 0);
        do_clear();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
